// File: rtl/div_iter.sv
// div_iter: iterative restoring divider, WIDTH-bit operands, BPC quotient bits
// retired per clock. Result is {remainder, quotient} with truncating signed
// semantics; divide-by-zero and cancel are handled by dedicated paths.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start_i; outputs cleared
// DIVZERO | divisor was zero; one cycle before reporting the flag
// ON      | running BPC restoring steps per edge, count = edges done
// END     | result_o / div_by_zero_o valid and held until start_i drops
module div_iter #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 cancel_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 div_by_zero_o
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd;      // dividend bits not yet consumed, quotient fills from the LSB
  logic [WIDTH-1:0] dvs;      // divisor magnitude
  logic [WIDTH-1:0] rem;      // partial remainder
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] op1_abs;
  logic [WIDTH-1:0] op2_abs;
  logic [WIDTH-1:0] dvd_nx;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
  end

  // BPC chained restoring steps, MSB first, with a (WIDTH+1)-bit trial subtract.
  always_comb begin
    trial  = '0;
    rem_nx = rem;
    dvd_nx = dvd;
    for (int i = 0; i < BPC; i++) begin
      trial = {rem_nx, dvd_nx[WIDTH-1]} - {1'b0, dvs};
      if (!trial[WIDTH]) rem_nx = trial[WIDTH-1:0];
      else               rem_nx = {rem_nx[WIDTH-2:0], dvd_nx[WIDTH-1]};
      dvd_nx = {dvd_nx[WIDTH-2:0], ~trial[WIDTH]};
    end
  end

  // Sign correction of the finished magnitudes.
  always_comb begin
    q_fin = neg_q ? -dvd : dvd;
    r_fin = neg_r ? -rem : rem;
  end

  // Sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      count         <= '0;
      dvd           <= '0;
      dvs           <= '0;
      rem           <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      result_o      <= '0;
      ready_o       <= 1'b0;
      busy_o        <= 1'b0;
      div_by_zero_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_o       <= 1'b0;
          busy_o        <= 1'b0;
          result_o      <= '0;
          div_by_zero_o <= 1'b0;
          if (start_i && !cancel_i) begin
            busy_o <= 1'b1;
            dvd    <= op1_abs;
            dvs    <= op2_abs;
            rem    <= '0;
            count  <= '0;
            neg_q  <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_r  <= signed_div_i & opdata1_i[WIDTH-1];
            state  <= (opdata2_i == '0) ? DIVZERO : ON;
          end
        end
        DIVZERO: begin
          busy_o <= 1'b0;
          if (cancel_i) begin
            state <= IDLE;
          end else begin
            state         <= END;
            ready_o       <= 1'b1;
            result_o      <= '0;
            div_by_zero_o <= 1'b1;
          end
        end
        ON: begin
          if (cancel_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            count  <= '0;
          end else if (count == LAST) begin
            state         <= END;
            busy_o        <= 1'b0;
            ready_o       <= 1'b1;
            result_o      <= {r_fin, q_fin};
            div_by_zero_o <= 1'b0;
          end else begin
            dvd   <= dvd_nx;
            rem   <= rem_nx;
            count <= count + ONE;
          end
        end
        END: begin
          // A held start_i keeps the result; a fresh request needs start_i low first.
          if (!start_i || cancel_i) begin
            state         <= IDLE;
            ready_o       <= 1'b0;
            result_o      <= '0;
            div_by_zero_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Parametrised iterative restoring divider. Next generation of the fixed 32-bit, radix-2 EX-stage divider.
- Adds configurable operand width, configurable bits retired per cycle, a divide-by-zero flag, a busy indicator and a defined signed-overflow result.
- Sits beside the EX stage. EX drives start and operands, and holds its stall request until ready_o.
- The pipeline flush path drives cancel_i.

Parameters:
- WIDTH, 32, operand width in bits. Must be a multiple of BPC.
- BPC, 1, quotient bits retired per cycle. Legal values: 1, 2, 4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- signed_div_i  in  1  1 = two's-complement divide, 0 = unsigned. Sampled at start.
- opdata1_i  in  WIDTH  dividend. Sampled at start.
- opdata2_i  in  WIDTH  divisor. Sampled at start.
- start_i  in  1  request. Level-sensitive, held by EX until ready_o.
- cancel_i  in  1  abort the current operation.
- result_o  out  2*WIDTH  {remainder, quotient}.
- ready_o  out  1  result_o valid.
- busy_o  out  1  operation in progress.
- div_by_zero_o  out  1  the completed operation had divisor 0.

Behaviour:
- Reset: rst=0 forces, asynchronously, state=IDLE, count=0, result_o=0, ready_o=0, busy_o=0, div_by_zero_o=0. Reset asserted mid-operation aborts immediately; no partial result is retained.
- Definitions: N = WIDTH/BPC. Edge E0 is the clock edge at which IDLE samples start_i=1 and cancel_i=0.
- IDLE:
  - Outputs: ready_o=0, busy_o=0, result_o=0.
  - start_i=1 and cancel_i=0: latch operands and sign mode. In signed mode, latch |opdata1|, |opdata2|, sign of dividend and sign of the quotient (XOR of the operand signs).
  - Next state: DIVZERO if opdata2_i==0, else ON with count=0 and partial remainder=0.
  - start_i=1 together with cancel_i=1: ignored, stay IDLE.
- DIVZERO:
  - busy_o=1.
  - Next edge (E1): go to END with result_o=0 and div_by_zero_o=1.
  - ready_o is therefore high after E1.
- ON:
  - busy_o=1.
  - Each edge performs BPC restoring steps, MSB first:
    - shift the partial remainder left, bringing in the next dividend bit;
    - trial-subtract the divisor using a (WIDTH+1)-bit subtractor;
    - on non-negative result, keep the difference and shift in quotient bit 1;
    - otherwise shift in 0.
  - count increments by 1 per edge.
  - Edges E1..EN iterate.
  - At edge E(N+1), go to END with the sign-corrected result registered and div_by_zero_o=0:
    - quotient negated if the quotient sign is 1;
    - remainder negated if the dividend was negative.
  - ready_o is high after E(N+1). Latency is N+1 cycles: 33 for WIDTH=32/BPC=1, 17 for BPC=2.
  - start_i deasserting during ON is ignored; the operation completes.
- END:
  - ready_o=1, busy_o=0. result_o and div_by_zero_o are held stable.
  - start_i=0 or cancel_i=1: next edge returns to IDLE, clearing ready_o, result_o and div_by_zero_o.
  - start_i stays high: remain in END. No back-to-back restart without a start_i low cycle.
- Cancel:
  - cancel_i=1 in ON or DIVZERO: next edge goes to IDLE, with all outputs as in reset.
  - ready_o never rises for the cancelled operation.
- Arithmetic rules:
  - Unsigned mode treats the operands as raw WIDTH-bit values.
  - Signed most-negative / -1: magnitude of the most-negative value is taken as unsigned 2^(WIDTH-1). Quotient wraps to the most-negative value; remainder is 0; no flag.
  - Remainder always satisfies |r| < |divisor|, and r takes the sign of the dividend (truncating division).
- The opdata inputs are not required to be stable after E0.

Test Plan:
- Unsigned divide, WIDTH=32, BPC=1: 100/7, start held high → busy_o=1 for E1..E32; ready_o rises after E33; result_o = {0x00000002, 0x0000000E}.
- Signed divide: -7/2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Repeat with 7/-2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero: 5/0 → ready_o after E1, div_by_zero_o=1, result_o=0. Drop start_i → next edge ready_o=0 and div_by_zero_o=0.
- Cancel: assert cancel_i for one cycle after E10 → IDLE at the next edge; ready_o never rises. A new 100/7 then completes correctly in 33 cycles.
- Reset: drop rst asynchronously mid-ON (between edges) → outputs 0 immediately, without a clock edge. After release, 0xFFFFFFFF/1 unsigned gives quotient 0xFFFFFFFF, remainder 0.
- BPC=2: signed 0x80000000 / 0xFFFFFFFF → ready_o after E17, quotient 0x80000000, remainder 0. Hold start_i high in END → result_o holds, no restart.
